regs_wb_arbiter: RTL and testbench

//  Write-back arbiter and queue in front of the single write port (addrD/dataD) of the Regs file.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/regs_wb_arbiter_if.sv | 47 ++++
 rtl/regs_wb_arbiter_wb_queue.sv | 80 ++++++++
 rtl/regs_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_regs_wb_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared register-file types for the write-back path: widths, the x0 index and the request record.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_MEM = 1'b1
    } rr_t;

endpackage

// File: rtl/regs_wb_arbiter_if.sv
// Requester, Regs write-port and status signals of the write-back arbiter.
// WB_BYPASS_EN adds the rs1/rs2 forwarding lookup signals.
interface regs_wb_arbiter_if;
    import riscv_pkg::*;

    logic            a_valid;
    logic            a_ready;
    logic [AW-1:0]   a_addr;
    logic [XLEN-1:0] a_data;
    logic            m_valid;
    logic            m_ready;
    logic [AW-1:0]   m_addr;
    logic [XLEN-1:0] m_data;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            busy;
`ifdef WB_BYPASS_EN
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            rs1_hit;
    logic [XLEN-1:0] rs1_data;
    logic            rs2_hit;
    logic [XLEN-1:0] rs2_data;

    modport slave (
        input  a_valid, a_addr, a_data, m_valid, m_addr, m_data, rs1_addr, rs2_addr,
        output a_ready, m_ready, wr_en, wr_addr, wr_data, busy,
               rs1_hit, rs1_data, rs2_hit, rs2_data
    );
    modport master (
        output a_valid, a_addr, a_data, m_valid, m_addr, m_data, rs1_addr, rs2_addr,
        input  a_ready, m_ready, wr_en, wr_addr, wr_data, busy,
               rs1_hit, rs1_data, rs2_hit, rs2_data
    );
`else
    modport slave (
        input  a_valid, a_addr, a_data, m_valid, m_addr, m_data,
        output a_ready, m_ready, wr_en, wr_addr, wr_data, busy
    );
    modport master (
        output a_valid, a_addr, a_data, m_valid, m_addr, m_data,
        input  a_ready, m_ready, wr_en, wr_addr, wr_data, busy
    );
`endif

endinterface

// File: rtl/regs_wb_arbiter_wb_queue.sv
// In-order circular write-back queue: two ordered push ports, one pop per cycle while non-empty, flush.
// WB_BYPASS_EN exposes the storage and head pointer for the forwarding search.
module wb_queue
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                push0_en,
    input  wb_req_t             push0_req,
    input  logic                push1_en,
    input  wb_req_t             push1_req,
    output logic                nonempty,
    output wb_req_t             head_req,
    output logic [CW-1:0]       count
`ifdef WB_BYPASS_EN
    ,
    output wb_req_t [DEPTH-1:0] entries,
    output logic [PW-1:0]       head_ptr
`endif
);

    wb_req_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d, tail_p1;
    logic [CW-1:0]       count_q, count_d;
    logic                pop;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        tail_p1 = tail_q + PW'(1);
        pop     = (count_q != '0);
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        // The entry presented this cycle is still written on flush; only later entries are dropped.
        if (flush) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push0_en) begin
                mem_d[tail_q] = push0_req;
            end
            if (push1_en) begin
                mem_d[tail_p1] = push1_req;
            end
            tail_d  = tail_q + PW'(push0_en) + PW'(push1_en);
            count_d = count_q + CW'(push0_en) + CW'(push1_en) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign nonempty = (count_q != '0);
    assign head_req = mem_q[head_q];
    assign count    = count_q;
`ifdef WB_BYPASS_EN
    assign entries  = mem_q;
    assign head_ptr = head_q;
`endif

endmodule

// File: rtl/regs_wb_arbiter.sv
// Write-back arbiter: round-robin ALU/MEM acceptance, x0 filtering and ordered enqueue into wb_queue.
// Optional WB_BYPASS_EN adds a combinational youngest-match search of queued entries.
module regs_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    regs_wb_arbiter_if.slave bus
);

    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam int unsigned   CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    rr_t           rr_q, rr_d;
    logic          a_rdy, m_rdy, acc_a, acc_m, push_a, push_m;
    logic          fst_en, snd_en, push0_en, push1_en, nonempty;
    wb_req_t       a_req, m_req, fst_req, snd_req, push0_req, push1_req, head_req;
    logic [CW-1:0] count;

    assign a_req = '{addr: bus.a_addr, data: bus.a_data};
    assign m_req = '{addr: bus.m_addr, data: bus.m_data};

    // With one slot left the favoured side is ready unconditionally; the other only if it is idle.
    always_comb begin
        a_rdy = 1'b0;
        m_rdy = 1'b0;
        if (!flush) begin
            if (count < CNT_LAST) begin
                a_rdy = 1'b1;
                m_rdy = 1'b1;
            end else if (count == CNT_LAST) begin
                if (rr_q == RR_ALU) begin
                    a_rdy = 1'b1;
                    m_rdy = !bus.a_valid;
                end else begin
                    m_rdy = 1'b1;
                    a_rdy = !bus.m_valid;
                end
            end
        end
    end

    always_comb begin
        acc_a  = bus.a_valid && a_rdy;
        acc_m  = bus.m_valid && m_rdy;
        push_a = acc_a && (bus.a_addr != REG_ZERO);
        push_m = acc_m && (bus.m_addr != REG_ZERO);
        if (rr_q == RR_ALU) begin
            fst_en  = push_a;
            fst_req = a_req;
            snd_en  = push_m;
            snd_req = m_req;
        end else begin
            fst_en  = push_m;
            fst_req = m_req;
            snd_en  = push_a;
            snd_req = a_req;
        end
        push0_en  = fst_en || snd_en;
        push0_req = fst_en ? fst_req : snd_req;
        push1_en  = fst_en && snd_en;
        push1_req = snd_req;

        rr_d = rr_q;
        if (acc_a && acc_m) begin
            rr_d = (rr_q == RR_ALU) ? RR_MEM : RR_ALU;
        end else if (acc_a) begin
            rr_d = RR_MEM;
        end else if (acc_m) begin
            rr_d = RR_ALU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= RR_ALU;
        end else begin
            rr_q <= rr_d;
        end
    end

`ifdef WB_BYPASS_EN
    wb_req_t [DEPTH-1:0] entries;
    logic [PW-1:0]       head_ptr;
`endif

    wb_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push0_en (push0_en),
        .push0_req(push0_req),
        .push1_en (push1_en),
        .push1_req(push1_req),
        .nonempty (nonempty),
        .head_req (head_req),
        .count    (count)
`ifdef WB_BYPASS_EN
        ,
        .entries  (entries),
        .head_ptr (head_ptr)
`endif
    );

    assign bus.a_ready = a_rdy;
    assign bus.m_ready = m_rdy;
    assign bus.wr_en   = nonempty;
    assign bus.wr_addr = head_req.addr;
    assign bus.wr_data = head_req.data;
    assign bus.busy    = nonempty;

`ifdef WB_BYPASS_EN
    logic [PW-1:0] idx;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        bus.rs1_hit  = 1'b0;
        bus.rs1_data = '0;
        bus.rs2_hit  = 1'b0;
        bus.rs2_data = '0;
        idx          = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_ptr + PW'(k);
            if (CW'(k) < count) begin
                if (bus.rs1_addr != REG_ZERO && entries[idx].addr == bus.rs1_addr) begin
                    bus.rs1_hit  = 1'b1;
                    bus.rs1_data = entries[idx].data;
                end
                if (bus.rs2_addr != REG_ZERO && entries[idx].addr == bus.rs2_addr) begin
                    bus.rs2_hit  = 1'b1;
                    bus.rs2_data = entries[idx].data;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Scoreboard bench for regs_wb_arbiter: expected writes queued on acceptance, compared as wr_en drains them.
module tb_regs_wb_arbiter;
    import riscv_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    regs_wb_arbiter_if bus();

    regs_wb_arbiter #(
        .DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int unsigned     n_tests = 0;
    int unsigned     n_fail  = 0;
    wb_req_t         sb[$];
    logic [XLEN-1:0] regs_m[32];
    bit              rr_m;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model sampled mid-cycle: readiness from the reference rule, then pop, then flush/push.
    always @(negedge clk) begin : monitor
        int unsigned used;
        bit          ea, em, acc_a, acc_m;
        wb_req_t     e, ra, rm;
        if (rst_n) begin
            used = sb.size();
            ea = 1'b0;
            em = 1'b0;
            if (!flush) begin
                if (used + 2 <= DEPTH) begin
                    ea = 1'b1;
                    em = 1'b1;
                end else if (used + 1 == DEPTH) begin
                    if (!rr_m) begin
                        ea = 1'b1;
                        em = !bus.a_valid;
                    end else begin
                        em = 1'b1;
                        ea = !bus.m_valid;
                    end
                end
            end
            check("a_ready", 32'(bus.a_ready), 32'(ea));
            check("m_ready", 32'(bus.m_ready), 32'(em));
            check("busy", 32'(bus.busy), 32'(used != 0));
            if (used != 0) begin
                e = sb.pop_front();
                check("wr_en", 32'(bus.wr_en), 32'd1);
                check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                check("wr_data", bus.wr_data, e.data);
                regs_m[bus.wr_addr] = bus.wr_data;
            end else begin
                check("wr_en_idle", 32'(bus.wr_en), 32'd0);
            end
            acc_a = bus.a_valid && ea;
            acc_m = bus.m_valid && em;
            ra.addr = bus.a_addr;
            ra.data = bus.a_data;
            rm.addr = bus.m_addr;
            rm.data = bus.m_data;
            if (flush) begin
                sb.delete();
            end else begin
                if (!rr_m) begin
                    if (acc_a && ra.addr != 0) sb.push_back(ra);
                    if (acc_m && rm.addr != 0) sb.push_back(rm);
                end else begin
                    if (acc_m && rm.addr != 0) sb.push_back(rm);
                    if (acc_a && ra.addr != 0) sb.push_back(ra);
                end
                if (acc_a && acc_m) rr_m = !rr_m;
                else if (acc_a) rr_m = 1'b1;
                else if (acc_m) rr_m = 1'b0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [XLEN-1:0] ad,
                         input logic mv, input logic [AW-1:0] ma, input logic [XLEN-1:0] md);
        bus.a_valid = av;
        bus.a_addr  = aa;
        bus.a_data  = ad;
        bus.m_valid = mv;
        bus.m_addr  = ma;
        bus.m_data  = md;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        flush = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 32 && sb.size() != 0; i++) next_cycle();
        next_cycle();
        check("drain_bound", 32'(sb.size()), 32'd0);
    endtask

    initial begin : stim
        int unsigned     na, nm;
        logic [XLEN-1:0] young;
        for (int i = 0; i < 32; i++) regs_m[i] = '0;
        rr_m = 1'b0;
        idle();
`ifdef WB_BYPASS_EN
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
`endif
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        next_cycle();

        // 1: reset with three entries queued
        drive(1'b1, 5'd1, 32'd100, 1'b1, 5'd2, 32'd200);
        next_cycle();
        drive(1'b1, 5'd5, 32'd500, 1'b1, 5'd6, 32'd600);
        next_cycle();
        idle();
        rst_n = 1'b0;
        #1;
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", bus.wr_data, 32'd0);
        sb.delete();
        rr_m = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        #1;
        check("rst_a_ready", 32'(bus.a_ready), 32'd1);
        check("rst_m_ready", 32'(bus.m_ready), 32'd1);
        next_cycle();

        // 2: single ALU write, one-cycle latency
        drive(1'b1, 5'd8, 32'd127, 1'b0, '0, '0);
        next_cycle();
        idle();
        check("t2_wr_en", 32'(bus.wr_en), 32'd1);
        check("t2_wr_addr", 32'(bus.wr_addr), 32'd8);
        check("t2_wr_data", bus.wr_data, 32'd127);
        next_cycle();
        check("t2_regs8", regs_m[8], 32'd127);

        // 4: x0 write acknowledged and dropped (also leaves ALU favoured)
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'd5653);
        #1;
        check("t4_m_ready", 32'(bus.m_ready), 32'd1);
        next_cycle();
        idle();
        check("t4_wr_en", 32'(bus.wr_en), 32'd0);
        check("t4_busy", 32'(bus.busy), 32'd0);

        // 3: same-cycle writes to x3, ALU favoured goes first
        drive(1'b1, 5'd3, 32'd145, 1'b1, 5'd3, 32'd137);
        next_cycle();
        idle();
        check("t3_first", bus.wr_data, 32'd145);
        next_cycle();
        check("t3_second", bus.wr_data, 32'd137);
        next_cycle();
        check("t3_regs3", regs_m[3], 32'd137);

        // 5: dual requests faster than drain; the monitor checks readiness against free slots
        na = 0;
        nm = 0;
        for (int c = 0; c < 40 && (na < 4 || nm < 4); c++) begin
            drive(na < 4, AW'(10 + na), 32'(1000 + na), nm < 4, AW'(20 + nm), 32'(2000 + nm));
            @(negedge clk);
            #1;
            if (bus.a_valid && bus.a_ready) na++;
            if (bus.m_valid && bus.m_ready) nm++;
            @(posedge clk);
            #2;
        end
        check("t5_accepts", 32'(na + nm), 32'd8);
        drain();

        // Pointer wrap: nine back-to-back ALU writes
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, AW'(i + 1), $urandom, 1'b0, '0, '0);
            next_cycle();
        end
        drain();

        // 6: flush with three entries; a concurrent request must be refused
        drive(1'b1, 5'd11, 32'd1, 1'b1, 5'd12, 32'd2);
        next_cycle();
        drive(1'b1, 5'd13, 32'd3, 1'b1, 5'd14, 32'd4);
        next_cycle();
        drive(1'b1, 5'd15, 32'd5, 1'b0, '0, '0);
        flush = 1'b1;
        #1;
        check("t6_a_ready", 32'(bus.a_ready), 32'd0);
        check("t6_wr_en_kept", 32'(bus.wr_en), 32'd1);
        next_cycle();
        idle();
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_wr_en", 32'(bus.wr_en), 32'd0);
        next_cycle();
        check("t6_wr_en_later", 32'(bus.wr_en), 32'd0);

`ifdef WB_BYPASS_EN
        drive(1'b1, 5'd4, 32'd137, 1'b0, '0, '0);
        bus.rs1_addr = 5'd4;
        bus.rs2_addr = 5'd0;
        next_cycle();
        idle();
        check("byp_rs1_hit", 32'(bus.rs1_hit), 32'd1);
        check("byp_rs1_data", bus.rs1_data, 32'd137);
        check("byp_rs2_x0", 32'(bus.rs2_hit), 32'd0);
        drain();
        young = rr_m ? 32'd11 : 32'd22;
        drive(1'b1, 5'd7, 32'd11, 1'b1, 5'd7, 32'd22);
        bus.rs2_addr = 5'd7;
        next_cycle();
        idle();
        check("byp_rs2_hit", 32'(bus.rs2_hit), 32'd1);
        check("byp_rs2_young", bus.rs2_data, young);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
